// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Recovers 11-bit UART frames (start, D0..D7 LSB first, parity, stop) from
//   the serial line using a 16x-style oversampling strobe, sampling each bit
//   at mid-period. Reports the byte plus parity/framing error status.
//
// Ports
//   clk               system clock
//   reset             asynchronous active-low reset
//   Rx_sample_ENABLE  one-clk strobe at OVERSAMPLE x baud
//   RxD               serial line, idle high, asynchronous to clk
//   Rx_DATA           last received byte (loaded on every stop sample)
//   Rx_VALID          one-clk pulse on a clean frame
//   Rx_PERROR         parity error on the last frame
//   Rx_FERROR         framing error (stop sampled 0) on the last frame
//   Rx_BUSY           high while a frame is in progress
module uart_rx_deframer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_sample_ENABLE,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfM1 = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  // Two-flop synchronizer; reset to the idle line level so reset never looks
  // like a start bit.
  logic r_sync1, r_sync2;
  logic w_rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_scnt, w_scnt_d;
  logic [2:0]      r_bcnt, w_bcnt_d;
  logic [7:0]      r_shreg, w_shreg_d;
  logic            r_par, w_par_d;
  logic [7:0]      r_data, w_data_d;
  logic            r_valid, w_valid_d;
  logic            r_perr, w_perr_d;
  logic            r_ferr, w_ferr_d;
  logic            w_perr_calc, w_ferr_calc;

  assign w_perr_calc = ((^r_shreg) ^ r_par) != PARITY_ODD;
  assign w_ferr_calc = ~w_rxs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_scnt  <= '0;
      r_bcnt  <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_scnt  <= w_scnt_d;
      r_bcnt  <= w_bcnt_d;
      r_shreg <= w_shreg_d;
      r_par   <= w_par_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_perr  <= w_perr_d;
      r_ferr  <= w_ferr_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_scnt_d  = r_scnt;
    w_bcnt_d  = r_bcnt;
    w_shreg_d = r_shreg;
    w_par_d   = r_par;
    w_data_d  = r_data;
    // Valid is cleared every clk so the pulse is one clk wide at any tick rate.
    w_valid_d = 1'b0;
    w_perr_d  = r_perr;
    w_ferr_d  = r_ferr;

    if (Rx_sample_ENABLE) begin
      case (r_state)
        StIdle: begin
          if (!w_rxs) begin
            w_state_d = StStart;
            w_scnt_d  = '0;
            w_perr_d  = 1'b0;
            w_ferr_d  = 1'b0;
          end
        end
        StStart: begin
          if (r_scnt == HalfM1) begin
            // Mid start bit: a high line here means the edge was a glitch.
            if (w_rxs) begin
              w_state_d = StIdle;
            end else begin
              w_state_d = StData;
              w_scnt_d  = '0;
              w_bcnt_d  = '0;
            end
          end else begin
            w_scnt_d = r_scnt + CntW'(1);
          end
        end
        StData: begin
          if (r_scnt == FullM1) begin
            w_scnt_d           = '0;
            w_shreg_d[r_bcnt]  = w_rxs;
            if (r_bcnt == 3'd7) begin
              w_state_d = StParity;
            end else begin
              w_bcnt_d = r_bcnt + 3'd1;
            end
          end else begin
            w_scnt_d = r_scnt + CntW'(1);
          end
        end
        StParity: begin
          if (r_scnt == FullM1) begin
            w_scnt_d  = '0;
            w_par_d   = w_rxs;
            w_state_d = StStop;
          end else begin
            w_scnt_d = r_scnt + CntW'(1);
          end
        end
        StStop: begin
          if (r_scnt == FullM1) begin
            w_scnt_d  = '0;
            w_data_d  = r_shreg;
            w_perr_d  = w_perr_calc;
            w_ferr_d  = w_ferr_calc;
            w_valid_d = ~w_perr_calc & ~w_ferr_calc;
            // A low stop bit may be a break; wait for the line to recover
            // before hunting for a new start edge.
            w_state_d = w_ferr_calc ? StWaitIdle : StIdle;
          end else begin
            w_scnt_d = r_scnt + CntW'(1);
          end
        end
        StWaitIdle: begin
          if (w_rxs) begin
            w_state_d = StIdle;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  assign Rx_DATA   = r_data;
  assign Rx_VALID  = r_valid;
  assign Rx_PERROR = r_perr;
  assign Rx_FERROR = r_ferr;
  assign Rx_BUSY   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: a driver serialises frames tick by tick and
// pushes the expected outcome into a queue; a monitor pops and compares every
// frame the DUT reports (Rx_VALID pulse or a fresh error flag).
module tb_uart_rx_deframer;

  localparam int unsigned OS = 16;

  logic       clk;
  logic       reset;
  logic       Rx_sample_ENABLE;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Rx_BUSY;

  uart_rx_deframer #(
    .OVERSAMPLE(OS),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Rx_sample_ENABLE(Rx_sample_ENABLE),
    .RxD             (RxD),
    .Rx_DATA         (Rx_DATA),
    .Rx_VALID        (Rx_VALID),
    .Rx_PERROR       (Rx_PERROR),
    .Rx_FERROR       (Rx_FERROR),
    .Rx_BUSY         (Rx_BUSY)
  );

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         fe;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   div   = 1;
  int   tcnt  = 0;
  bit   prev_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick strobe, one clk wide every 'div' clks; changed on negedge.
  initial Rx_sample_ENABLE = 1'b0;
  always @(negedge clk) begin
    if (tcnt >= div - 1) begin
      Rx_sample_ENABLE = 1'b1;
      tcnt = 0;
    end else begin
      Rx_sample_ENABLE = 1'b0;
      tcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: one frame outcome per valid pulse or per fresh error flag.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (Rx_VALID || ((Rx_PERROR || Rx_FERROR) && !prev_err)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got data=%0h pe=%0b fe=%0b valid=%0b required none",
                   Rx_DATA, Rx_PERROR, Rx_FERROR, Rx_VALID);
        end else begin
          e = exp_q.pop_front();
          chk("frame_data", 32'(Rx_DATA), 32'(e.d));
          chk("frame_perr", 32'(Rx_PERROR), 32'(e.pe));
          chk("frame_ferr", 32'(Rx_FERROR), 32'(e.fe));
          chk("frame_valid", 32'(Rx_VALID), 32'(!(e.pe || e.fe)));
        end
      end
    end
    prev_err = Rx_PERROR || Rx_FERROR;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (Rx_sample_ENABLE !== 1'b1) @(posedge clk);
    end
  endtask

  // Reference outcome straight from the frame contents.
  task automatic expect_frame(input logic [7:0] d, input bit p, input bit s);
    exp_t e;
    e.d  = d;
    e.pe = ((^d) ^ p) != 1'b0;
    e.fe = !s;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit s, input bit chk_clear);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RxD = fr[i];
      if (chk_clear && i == 2) begin
        chk("perr_cleared_at_start", 32'(Rx_PERROR), 0);
        chk("ferr_cleared_at_start", 32'(Rx_FERROR), 0);
        chk("busy_in_frame", 32'(Rx_BUSY), 1);
      end
      wait_ticks(OS);
      #1;
    end
  endtask

  task automatic idle_gap(input int n);
    RxD = 1'b1;
    if (n > 0) begin
      wait_ticks(n);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, 32'(Rx_DATA), 0);
    chk({tag, "_valid"}, 32'(Rx_VALID), 0);
    chk({tag, "_perr"}, 32'(Rx_PERROR), 0);
    chk({tag, "_ferr"}, 32'(Rx_FERROR), 0);
    chk({tag, "_busy"}, 32'(Rx_BUSY), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    bit         p, s;
    int         gap;

    reset = 1'b0;
    RxD   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b1;
    idle_gap(OS);

    // Clean byte.
    expect_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("busy_after_a5", 32'(Rx_BUSY), 0);
    idle_gap(OS);

    // Glitch: 4 ticks low, then high.
    RxD = 1'b0;
    wait_ticks(4);
    #1;
    RxD = 1'b1;
    wait_ticks(OS / 2);
    #1;
    chk("glitch_busy", 32'(Rx_BUSY), 0);
    chk("glitch_data", 32'(Rx_DATA), 32'h A5);
    chk("glitch_perr", 32'(Rx_PERROR), 0);
    chk("glitch_ferr", 32'(Rx_FERROR), 0);
    idle_gap(OS);

    // Parity error, then a clean frame clears the flag at start detection.
    expect_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    chk("perr_held", 32'(Rx_PERROR), 1);
    idle_gap(OS);
    expect_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    idle_gap(OS);

    // Framing error followed by a 30-bit break.
    expect_frame(8'h7E, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
    wait_ticks(30 * OS);
    #1;
    chk("break_busy", 32'(Rx_BUSY), 1);
    chk("break_ferr", 32'(Rx_FERROR), 1);
    chk("break_data", 32'(Rx_DATA), 32'h7E);
    idle_gap(OS);
    chk("break_recovered_busy", 32'(Rx_BUSY), 0);

    // Back-to-back frames with no idle gap.
    expect_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    expect_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    expect_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    idle_gap(OS);

    // Reset in the middle of D4 of an all-zero frame.
    for (int i = 0; i < 5; i++) begin
      RxD = 1'b0;
      wait_ticks(OS);
      #1;
    end
    wait_ticks(OS / 2);
    #1;
    chk("midframe_busy", 32'(Rx_BUSY), 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_gap(2 * OS);
    expect_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    idle_gap(OS);

    // Randomised frames with occasional parity/stop errors and tick gaps.
    for (int n = 0; n < 20; n++) begin
      div = int'($urandom_range(1, 3));
      d   = 8'($urandom);
      p   = ^d;
      if ($urandom_range(0, 3) == 0) p = !p;
      s   = ($urandom_range(0, 4) != 0);
      expect_frame(d, p, s);
      send_frame(d, p, s, 1'b0);
      gap = s ? int'($urandom_range(0, OS)) : OS + int'($urandom_range(0, OS));
      idle_gap(gap);
    end

    div = 1;
    idle_gap(4 * OS);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("final_busy", 32'(Rx_BUSY), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
